// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants, types and the write-enable decode helper for the
//   32 x 64-bit register file.
//   Contents: DATA_W, NREG, ZERO_REG, reg_idx_t, data_t, onehot_dec_t,
//             onehot_to_idx().
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int NREG     = 32;
  localparam int ZERO_REG = 31;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    reg_idx_t idx;
    logic     valid;
  } onehot_dec_t;

  // Encodes a one-hot vector to a binary index. valid is high only when
  // exactly one bit is set; idx is meaningful only when valid is high.
  function automatic onehot_dec_t onehot_to_idx(input logic [NREG-1:0] vec);
    onehot_dec_t r;
    r.idx   = '0;
    // A nonzero value with no bit left after clearing its lowest set bit.
    r.valid = (vec != '0) && ((vec & (vec - NREG'(1))) == '0);
    for (int i = 0; i < NREG; i++) begin
      if (vec[i]) r.idx = r.idx | reg_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_32x64_mux_32_1.sv
// mux_32_1
//   DATA_W-wide 32:1 combinational selector, one per register-file read port.
//   Ports:
//     din  - 32 candidate words
//     sel  - 5-bit select
//     dout - selected word
module mux_32_1
  import regfile_pkg::*;
(
  input  data_t    din [NREG],
  input  reg_idx_t sel,
  output data_t    dout
);

  assign dout = din[sel];

endmodule

// File: rtl/regfile_32x64.sv
// regfile_32x64
//   32-entry, 64-bit register file with two combinational read ports.
//   X31 has no storage and always reads zero. A sticky flag records any
//   write-enable vector with two or more bits set; such a write is dropped.
//   Optional feature macro: REGFILE_BYPASS_EN -- when defined, a valid
//   one-hot write to X0..X30 is forwarded combinationally to any read port
//   addressing the same register in the same cycle.
//   Ports:
//     clk        - rising-edge clock
//     reset_n    - asynchronous active-low reset (clears registers and flag)
//     WriteEn    - one-hot write enable (all zero = no write)
//     WriteData  - write data
//     ReadReg1/2 - read indices
//     ReadData1/2- read data
//     OneHotErr  - sticky multi-bit write-enable flag
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREG-1:0]   WriteEn,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              OneHotErr
);

  data_t       regs_q [NREG-1];
  data_t       regs_d [NREG-1];
  logic        one_hot_err_q;
  logic        one_hot_err_d;
  onehot_dec_t wr_dec;
  logic        wr_multi;
  data_t       rd_src [NREG];
  data_t       mux_rd1;
  data_t       mux_rd2;

  assign wr_dec   = onehot_to_idx(WriteEn);
  // Nonzero but not exactly one bit: an illegal multi-hot vector.
  assign wr_multi = (WriteEn != '0) && !wr_dec.valid;

  always_comb begin
    regs_d = regs_q;
    // A write to index 31 matches no physical entry and falls away here.
    for (int i = 0; i < NREG - 1; i++) begin
      if (wr_dec.valid && (wr_dec.idx == reg_idx_t'(i))) regs_d[i] = WriteData;
    end
    one_hot_err_d = one_hot_err_q | wr_multi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG - 1; i++) regs_q[i] <= '0;
      one_hot_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG - 1; i++) regs_q[i] <= regs_d[i];
      one_hot_err_q <= one_hot_err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG - 1; i++) rd_src[i] = regs_q[i];
    rd_src[ZERO_REG] = '0;
  end

  mux_32_1 u_mux_rd1 (.din(rd_src), .sel(ReadReg1), .dout(mux_rd1));
  mux_32_1 u_mux_rd2 (.din(rd_src), .sel(ReadReg2), .dout(mux_rd2));

`ifdef REGFILE_BYPASS_EN
  logic fwd_en;
  // Forwarding is held off during reset so reads stay zero while reset_n is low.
  assign fwd_en    = reset_n && wr_dec.valid && (wr_dec.idx != reg_idx_t'(ZERO_REG));
  assign ReadData1 = (fwd_en && (ReadReg1 == wr_dec.idx)) ? WriteData : mux_rd1;
  assign ReadData2 = (fwd_en && (ReadReg2 == wr_dec.idx)) ? WriteData : mux_rd2;
`else
  assign ReadData1 = mux_rd1;
  assign ReadData2 = mux_rd2;
`endif

  assign OneHotErr = one_hot_err_q;

endmodule

// File: tb/tb_regfile_32x64.sv
module tb_regfile_32x64;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREG-1:0]   WriteEn;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        ReadReg1, ReadReg2;
  logic [DATA_W-1:0] ReadData1, ReadData2;
  logic              OneHotErr;

  regfile_32x64 dut (
    .clk(clk), .reset_n(reset_n), .WriteEn(WriteEn), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .OneHotErr(OneHotErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    data_t exp1;
    data_t exp2;
    logic  experr;
  } exp_t;

  exp_t  sb [$];
  data_t model [NREG];
  logic  m_err;
  int    checks = 0;
  int    failures = 0;

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) model[i] = '0;
    m_err = 1'b0;
  endfunction

  // Architectural effect of one clock edge.
  function automatic void model_edge(input logic [NREG-1:0] we, input data_t wd);
    int n;
    n = $countones(we);
    if (n >= 2) m_err = 1'b1;
    else if (n == 1) begin
      for (int i = 0; i < NREG - 1; i++) if (we[i]) model[i] = wd;
    end
  endfunction

  function automatic data_t exp_read(input int idx);
    if (!reset_n || idx == ZERO_REG) return '0;
`ifdef REGFILE_BYPASS_EN
    if ($countones(WriteEn) == 1 && WriteEn[idx]) return WriteData;
`endif
    return model[idx];
  endfunction

  task automatic push_exp(input string nm);
    exp_t e;
    e.name   = nm;
    e.exp1   = exp_read(int'(ReadReg1));
    e.exp2   = exp_read(int'(ReadReg2));
    e.experr = m_err;
    sb.push_back(e);
  endtask

  // Called at posedge+1; the monitor checks at the following negedge.
  task automatic drive_cycle(input logic [NREG-1:0] we, input data_t wd,
                             input int r1, input int r2, input string nm);
    WriteEn = we; WriteData = wd;
    ReadReg1 = 5'(r1); ReadReg2 = 5'(r2);
    push_exp(nm);
    @(posedge clk);
    if (reset_n) model_edge(we, wd);
    #1;
  endtask

  function automatic logic [NREG-1:0] bit_at(input int i);
    logic [NREG-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (ReadData1 !== e.exp1) begin
        failures++;
        $display("FAIL %s rd1 rr=%0d actual=%h required=%h", e.name, ReadReg1, ReadData1, e.exp1);
      end
      checks++;
      if (ReadData2 !== e.exp2) begin
        failures++;
        $display("FAIL %s rd2 rr=%0d actual=%h required=%h", e.name, ReadReg2, ReadData2, e.exp2);
      end
      checks++;
      if (OneHotErr !== e.experr) begin
        failures++;
        $display("FAIL %s err actual=%b required=%b", e.name, OneHotErr, e.experr);
      end
    end
  end

  initial begin
    reset_n = 1'b0; WriteEn = '0; WriteData = '0; ReadReg1 = '0; ReadReg2 = '0;
    model_clear();
    @(posedge clk); #1;

    // Reads in reset are zero; writes (including illegal ones) are ignored.
    for (int i = 0; i < NREG; i++)
      drive_cycle((i % 2 == 0) ? bit_at(i) : 32'h0000_0028,
                  {$urandom, $urandom}, i, NREG - 1 - i, "reset_read");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      drive_cycle('0, '0, 2 * i, 2 * i + 1, "post_reset_zero");

    // Write sweep then read sweep.
    for (int i = 0; i < NREG - 1; i++)
      drive_cycle(bit_at(i), 64'hA5A5_0000_0000_0000 + 64'(i),
                  $urandom_range(0, 31), $urandom_range(0, 31), "write_sweep");
    for (int i = 0; i < NREG; i++)
      drive_cycle('0, '0, i, (i + 7) % NREG, "read_sweep");

    // X31 ignores writes.
    drive_cycle(32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, "x31_write");
    drive_cycle('0, '0, 31, 0, "x31_read");

    // Same-cycle read of the register being written.
    drive_cycle(bit_at(7), 64'h11, 0, 1, "x7_preload");
    drive_cycle(bit_at(7), 64'h22, 7, 7, "x7_same_cycle");
    drive_cycle('0, '0, 7, 6, "x7_after_edge");

    // Multi-hot write is dropped and sets the sticky flag.
    drive_cycle(bit_at(3), 64'h1, 0, 0, "pre_x3");
    drive_cycle(bit_at(5), 64'h2, 3, 0, "pre_x5");
    drive_cycle(32'h0000_0028, 64'hDEAD, 3, 5, "multi_hot");
    drive_cycle('0, '0, 3, 5, "multi_hot_after");
    for (int i = 0; i < 10; i++)
      drive_cycle(bit_at($urandom_range(8, 30)), {$urandom, $urandom},
                  $urandom_range(0, 31), 5, "err_sticky");

    // Random traffic, occasional multi-hot vectors.
    for (int i = 0; i < 300; i++) begin
      logic [NREG-1:0] we;
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) we = '0;
      else if (k == 1) we = bit_at($urandom_range(0, 15)) | bit_at($urandom_range(16, 31));
      else we = bit_at($urandom_range(0, 31));
      drive_cycle(we, {$urandom, $urandom}, $urandom_range(0, 31),
                  $urandom_range(0, 31), "random");
    end

    // Async reset mid-burst, between edges, with a valid write presented.
    WriteEn = bit_at(9); WriteData = 64'h1234; ReadReg1 = 5'd9; ReadReg2 = 5'd3;
    #2;
    reset_n = 1'b0;
    model_clear();
    push_exp("async_reset");
    @(posedge clk); #1;
    drive_cycle(32'h0000_0028, 64'hBEEF, 9, 1, "in_reset");
    reset_n = 1'b1;
    drive_cycle(bit_at(1), 64'h5, 9, 3, "post_reset_write");
    drive_cycle('0, '0, 1, 9, "post_reset_read");
    for (int i = 0; i < 20; i++)
      drive_cycle(bit_at($urandom_range(0, 31)), {$urandom, $urandom},
                  $urandom_range(0, 31), $urandom_range(0, 31), "tail_random");

    WriteEn = '0;
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_32x64.md
# regfile_32x64

Thirty-two-entry, 64-bit register file for the single-cycle CPU. It consumes the one-hot write-enable vector produced by the 5:32 write-select decoder, which is already gated by RegWrite. It provides two combinational read ports to the ALU and datapath. X31 is hardwired to zero, and a sticky error flag records any write-enable vector that is not one-hot.

## Interface
- DATA_W, 64, register width in bits
- NREG, 32, register count; fixed at 32 to match the 5-bit select
- ZERO_REG, 31, index that always reads zero and ignores writes

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- WriteEn  input  32  one-hot write enable from the write-select decoder; all zero means no write
- WriteData  input  DATA_W  data to write
- ReadReg1  input  5  read port 1 index
- ReadReg2  input  5  read port 2 index
- ReadData1  output  DATA_W  contents of register ReadReg1
- ReadData2  output  DATA_W  contents of register ReadReg2
- OneHotErr  output  1  sticky flag; set when WriteEn had two or more bits set

## Operation
- Storage: 31 physical registers, X0–X30. X31 has no storage.
- Write path, evaluated at each rising clk edge:
  - WriteEn == 0: no change.
  - Exactly one bit i set, i != 31: reg[i] <= WriteData.
  - Only bit 31 set: no write, no error.
  - Two or more bits set: no register is written, including any valid-looking bit, and OneHotErr <= 1.
- OneHotErr stays set until reset_n is asserted; it has no other clear path.
- Read path: fully combinational 32:1 selection per port. Index 31 returns 0.
- Both ports may read the same index; both return identical data.
- Write index encoding: an internal one-hot-to-binary encode of WriteEn, qualified by a single-bit-set check, drives the bypass compare.

## Timing
- Reset: when reset_n goes low, all registers clear to 0 and OneHotErr clears to 0 immediately, without waiting for a clock edge.
  - While in reset, ReadData1 and ReadData2 are 0 for every index.
  - Writes are ignored while reset_n is low.
  - The first write is accepted at the first rising clk edge after reset_n goes high.
- Write latency: data is visible on the read ports after the rising edge that captures it; there is no extra pipeline stage.
- Read latency: zero cycles, purely combinational from ReadRegN and the current register state.
- Same-cycle read of the register being written: the behaviour is set by the configuration macro below.
- Reset asserted mid-write, in the same cycle as a valid WriteEn: reset wins; the register stays 0.
- An erroneous WriteEn in the same cycle as reset: OneHotErr stays 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When WriteEn is a valid one-hot with index i != 31, a read port whose ReadRegN == i outputs WriteData combinationally in that same cycle.
  - Index 31 still reads 0.
  - A WriteEn with multiple bits set never forwards.
- REGFILE_BYPASS_EN undefined:
  - Read ports always show the stored value.
  - A same-cycle read of the register being written returns the old value until the edge.

## Structure
- Package regfile_pkg holds:
  - Constants DATA_W, NREG and ZERO_REG.
  - Typedef reg_idx_t (logic [4:0]).
  - Typedef data_t (logic [DATA_W-1:0]).
  - Function onehot_to_idx, returning the index and a valid bit (exactly one bit set).
- Sub-module mux_32_1: a DATA_W-wide 32:1 selector, instantiated once per read port.
- The register array, write logic, error flag and bypass logic live in regfile_32x64.

## Test plan
- Reset check: assert reset_n=0, sweep ReadReg1 and ReadReg2 over 0..31 → all reads 0 and OneHotErr=0.
- Write/read sweep: write X_i = 64'hA5A5_0000_0000_0000 + i for i=0..30, one per cycle, then read every index on both ports → each X_i matches its value and X31 reads 0.
- Zero register: WriteEn=32'h8000_0000 with WriteData=64'hFFFF_FFFF_FFFF_FFFF, then read X31 → returns 0 and OneHotErr=0.
- One-hot error: preload X3=1 and X5=2, then drive WriteEn=32'h0000_0028 with WriteData=64'hDEAD → X3 stays 1, X5 stays 2, OneHotErr=1. OneHotErr is still 1 after 10 clean writes and clears only on reset_n=0.
- Same-cycle read: preload X7=64'h11, then write X7=64'h22 with ReadReg1=7 in the same cycle.
  - With REGFILE_BYPASS_EN: ReadData1=64'h22 before the edge.
  - Without REGFILE_BYPASS_EN: ReadData1=64'h11 before the edge and 64'h22 after it.
- Async reset mid-stream: during a write burst, drop reset_n between clock edges → all reads go to 0 immediately; after release, a write of X1=64'h5 is visible after the next edge.
